ram_16x8_ctrl: RTL and testbench

//  Initiator side of the 16x8 RAM port (addr/RW/i_data/o_data).
//  - Accepts single read/write requests from a host over a valid/ready handshake.
//  - Sequences the RAM port and returns read data over a valid/ready response channel.
//  - Provides a fill command that writes one byte to every RAM location.
//  - Sits between host logic and the RAM instance, which it drives directly.

---
 rtl/ram_16x8_ctrl.sv | 138 +++++++++++++
 tb/tb_ram_16x8_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_16x8_ctrl.sv
// Host-side controller for a 16x8 synchronous RAM: single read/write requests over
// valid/ready, read data returned on a valid/ready response channel, plus a whole-array fill.
module ram_16x8_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] addr,
    output logic              RW,
    output logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] o_data
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CAP, S_RSP, S_FILL} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] i_data_q, i_data_d;
    logic              rw_q, rw_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    // req_ready_q gates acceptance so nothing is taken in the first cycle after reset
    logic accept, fill_last;
    assign accept    = (state_q == S_IDLE) && req_ready_q;
    assign fill_last = (addr_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && fill_start)     state_d = S_FILL;
                else if (accept && req_valid) state_d = req_we ? S_WR : S_RD;
            end
            S_WR:   state_d = S_IDLE;
            S_RD:   state_d = S_CAP;
            S_CAP:  state_d = S_RSP;
            S_RSP:  if (rsp_ready) state_d = S_IDLE;
            S_FILL: if (fill_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so each register is loaded with the value for the state being entered
    always_comb begin
        addr_d      = addr_q;
        i_data_d    = i_data_q;
        rw_d        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept && fill_start) begin
                    addr_d   = '0;
                    i_data_d = fill_data;
                    rw_d     = 1'b1;
                end else if (accept && req_valid) begin
                    addr_d = req_addr;
                    if (req_we) begin
                        i_data_d = req_wdata;
                        rw_d     = 1'b1;
                    end
                end
            end
            S_CAP: begin
                rsp_data_d  = o_data;
                rsp_addr_d  = addr_q;
                rsp_valid_d = 1'b1;
            end
            S_RSP:  rsp_valid_d = !rsp_ready;
            S_FILL: begin
                if (!fill_last) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rw_d   = 1'b1;
                end
            end
            default: ;
        endcase
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            i_data_q    <= '0;
            rw_q        <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            i_data_q    <= i_data_d;
            rw_q        <= rw_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign addr      = addr_q;
    assign i_data    = i_data_q;
    assign RW        = rw_q;
    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ram_16x8_ctrl.sv
// Bench for ram_16x8_ctrl: behavioural RAM, array reference model, queue scoreboard
// with an independent response monitor, directed scenarios followed by random traffic.
module tb_ram_16x8_ctrl;

    logic       clk, rst_n;
    logic       req_valid, req_ready, req_we;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       fill_start;
    logic [7:0] fill_data;
    logic       busy, rsp_valid, rsp_ready;
    logic [3:0] rsp_addr;
    logic [7:0] rsp_data;
    logic [3:0] addr;
    logic       RW;
    logic [7:0] i_data, o_data;

    ram_16x8_ctrl #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .fill_start(fill_start), .fill_data(fill_data),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .addr(addr), .RW(RW), .i_data(i_data), .o_data(o_data)
    );

    // RAM instance model: write on RW, registered read
    logic [7:0] ram [16] = '{default: 8'h00};
    always @(posedge clk) begin
        if (RW) ram[addr] <= i_data;
        o_data <= ram[addr];
    end

    // Reference: what the RAM should contain given all accepted commands
    logic [7:0] mem_m [16] = '{default: 8'h00};
    logic [3:0] exp_a [$];
    logic [7:0] exp_d [$];
    int         exp_c [$];

    int checks = 0, errors = 0;
    int cyc = 0, last_acc = 0, rr_mode = 0;
    bit in_rsp = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // rsp_ready: 0 = always ready, 1 = random, 2 = held low
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Response monitor: data held against queue head every valid cycle, popped on handshake
    initial forever begin
        @(negedge clk);
        if (rst_n && rsp_valid) begin
            if (exp_a.size() == 0) chk(0, "rsp_unexpected", rsp_addr, 0);
            else begin
                // acceptance edge k -> rsp_valid after edge k+2 (3rd cycle after acceptance cycle)
                if (!in_rsp) chk(cyc - exp_c[0] == 2, "rsp_latency", cyc - exp_c[0], 2);
                chk(rsp_addr == exp_a[0], "rsp_addr", rsp_addr, exp_a[0]);
                chk(rsp_data == exp_d[0], "rsp_data", rsp_data, exp_d[0]);
                chk(busy == 1'b1, "busy_in_rsp", busy, 1);
                if (rsp_ready) begin
                    void'(exp_a.pop_front()); void'(exp_d.pop_front()); void'(exp_c.pop_front());
                end
            end
            in_rsp = !rsp_ready;
        end else begin
            if (rst_n && in_rsp) chk(0, "rsp_dropped", 0, 1);
            in_rsp = 0;
        end
    end

    // kind: 0 read, 1 write, 2 fill. Called just after a posedge; returns at the negedge after acceptance.
    task automatic issue(input int kind, input logic [3:0] a, input logic [7:0] d);
        int n = 0;
        req_valid = (kind < 2); req_we = (kind == 1); req_addr = a; req_wdata = d;
        fill_start = (kind == 2); fill_data = d;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 100) begin chk(0, "accept_timeout", n, 100); break; end
        end
        last_acc = cyc + 1;
        case (kind)
            0: begin exp_a.push_back(a); exp_d.push_back(mem_m[a]); exp_c.push_back(cyc + 1); end
            1: mem_m[a] = d;
            default: for (int i = 0; i < 16; i++) mem_m[i] = d;
        endcase
        @(posedge clk); #1;
        req_valid = 1'b0; fill_start = 1'b0;
        @(negedge clk);
        chk(busy == 1'b1, "busy_after_accept", busy, 1);
        chk(req_ready == 1'b0, "ready_low_busy", req_ready, 0);
        chk(RW == (kind != 0), "rw_first", RW, kind != 0);
        chk(addr == ((kind == 2) ? 4'd0 : a), "addr_first", addr, (kind == 2) ? 0 : a);
        if (kind != 0) chk(i_data == d, "idata_first", i_data, d);
    endtask

    task automatic fill_rest(input logic [7:0] d);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            chk(RW == 1'b1 && addr == 4'(i) && i_data == d && busy, "fill_step", {RW, addr}, {1'b1, 4'(i)});
        end
        @(negedge clk);
        chk(RW == 1'b0 && busy == 1'b0 && req_ready == 1'b1, "fill_end", {RW, busy, req_ready}, 3'b001);
        chk(addr == 4'd15, "fill_no_wrap", addr, 15);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_a.size() != 0) && n < 200) begin @(negedge clk); n++; end
        chk(n < 200, "idle_timeout", n, 200);
        @(posedge clk); #1;
    endtask

    initial begin
        int n, a1;
        rst_n = 1'b0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        fill_start = 0; fill_data = 0;
        #12;
        chk({RW, busy, req_ready, rsp_valid} == 4'b0 && addr == 0 && i_data == 0 && rsp_data == 0 && rsp_addr == 0,
            "reset_outputs", {RW, busy, req_ready, rsp_valid}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk(req_ready == 1'b1 && busy == 1'b0, "ready_after_reset", {req_ready, busy}, 2'b10);

        // 1: reset in the middle of a fill at address 5
        issue(2, 4'd0, 8'hC3);
        for (int i = 5; i < 16; i++) mem_m[i] = 8'h00;
        n = 0;
        while (addr != 4'd5 && n < 20) begin @(negedge clk); n++; end
        chk(addr == 4'd5, "reach_fill_addr5", addr, 5);
        rst_n = 1'b0; #1;
        chk(RW == 1'b0 && addr == 0 && i_data == 0 && busy == 0 && req_ready == 0 && rsp_valid == 0,
            "reset_mid_fill", {RW, busy, req_ready, addr}, 0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk(req_ready == 1'b1 && busy == 1'b0 && RW == 1'b0, "idle_after_abort", {req_ready, busy, RW}, 3'b100);
        issue(0, 4'd4, 8'h0);
        issue(0, 4'd5, 8'h0);
        wait_idle();

        // 2: two writes, two reads
        rr_mode = 0;
        issue(1, 4'd0, 8'hAA);
        issue(1, 4'd7, 8'h55);
        issue(0, 4'd7, 8'h0);
        issue(0, 4'd0, 8'h0);
        wait_idle();

        // 3: response held by host for 4 cycles
        issue(1, 4'd1, 8'h2A);
        rr_mode = 2;
        issue(0, 4'd1, 8'h0);
        n = 0;
        while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
        for (int i = 0; i < 4; i++) begin
            chk(rsp_valid && rsp_data == 8'h2A, "rsp_hold", {rsp_valid, rsp_data}, {1'b1, 8'h2A});
            if (i < 3) @(negedge clk);
        end
        rr_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk(rsp_valid == 1'b0 && busy == 1'b0 && req_ready == 1'b1, "rsp_release", {rsp_valid, busy, req_ready}, 3'b001);
        @(posedge clk); #1;

        // 4: fill then spot reads
        issue(2, 4'd0, 8'h3C);
        fill_rest(8'h3C);
        @(posedge clk); #1;
        issue(0, 4'd0, 8'h0);
        issue(0, 4'd8, 8'h0);
        issue(0, 4'd15, 8'h0);
        wait_idle();

        // 5: fill_start and a read in the same cycle
        req_valid = 1; req_we = 0; req_addr = 4'd4; fill_start = 1; fill_data = 8'h96;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h96;
        @(posedge clk); #1; fill_start = 0;
        @(negedge clk);
        chk(RW == 1'b1 && addr == 0 && req_ready == 1'b0, "fill_priority", {RW, addr, req_ready}, 6'b100000);
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 40);
        chk(n == 16, "pending_read_wait", n, 16);
        exp_a.push_back(4'd4); exp_d.push_back(mem_m[4]); exp_c.push_back(cyc + 1);
        @(posedge clk); #1; req_valid = 0;
        wait_idle();

        // 6: last write to address 15 wins; writes accepted 2 cycles apart
        issue(1, 4'd15, 8'h11);
        a1 = last_acc;
        issue(1, 4'd15, 8'h22);
        chk(last_acc - a1 == 2, "write_spacing", last_acc - a1, 2);
        @(negedge clk);
        chk(busy == 1'b0 && req_ready == 1'b1, "idle_after_wr", {busy, req_ready}, 2'b01);
        @(posedge clk); #1;
        issue(0, 4'd15, 8'h0);
        wait_idle();

        // random traffic with random response back-pressure
        rr_mode = 1;
        for (int k = 0; k < 80; k++) begin
            int kind;
            kind = ($urandom_range(0, 15) == 0) ? 2 : int'($urandom_range(0, 1));
            issue(kind, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
        wait_idle();
        rr_mode = 0;
        chk(exp_a.size() == 0, "queue_drained", exp_a.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
